// File: rtl/controle_varredura_servo_pkg.sv
// Shared state codes and position limits for the servo sweep sequencer.
package controle_varredura_servo_pkg;

  typedef enum logic [3:0] {
    INICIAL   = 4'd0,
    POSICIONA = 4'd1,
    ASSENTA   = 4'd2,
    MEDE      = 4'd3,
    AGUARDA   = 4'd4,
    PROXIMA   = 4'd5
  } estado_t;

  localparam logic [2:0] POS_MIN = 3'd0;
  localparam logic [2:0] POS_MAX = 3'd7;

endpackage

// File: rtl/controle_varredura_servo_contador_timer.sv
// Cycle counter with synchronous clear, count enable and terminal-count flag.
module contador_timer #(
  parameter  int M = 25_000_000,
  localparam int W = $clog2(M + 1)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limite,
  output logic         fim
);

  logic [W-1:0] contagem_q;
  logic [W-1:0] contagem_d;

  always_comb begin
    contagem_d = contagem_q;
    if (clear) begin
      contagem_d = '0;
    end else if (enable) begin
      contagem_d = contagem_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      contagem_q <= '0;
    end else begin
      contagem_q <= contagem_d;
    end
  end

  assign fim = (contagem_q == limite);

endmodule

// File: rtl/controle_varredura_servo.sv
// Servo sweep sequencer: steps position 0..7..0, settles, requests a measurement
// and waits for it (or times out) at every position.
module controle_varredura_servo
  import controle_varredura_servo_pkg::*;
#(
  parameter int ASSENTAMENTO = 25_000_000,
  parameter int TIMEOUT      = 5_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ligar,
  input  logic       medida_pronta,
  output logic [2:0] posicao,
  output logic       medir,
  output logic       pronto_pos,
  output logic       erro_timeout,
  output logic       sentido,
  output logic [3:0] db_estado
);

  localparam int MAX_CONTA = (ASSENTAMENTO > TIMEOUT) ? ASSENTAMENTO : TIMEOUT;
  localparam int W         = $clog2(MAX_CONTA + 1);

  estado_t    estado_q, estado_d;
  logic [2:0] posicao_q, posicao_d;
  logic       sentido_q, sentido_d;
  logic       medir_q, medir_d;
  logic       pronto_pos_q, pronto_pos_d;
  logic       erro_q, erro_d;
  logic       limpa, habilita, fim;
  logic [W-1:0] limite;

  // One counter serves both the settle wait and the measurement timeout.
  assign limite = (estado_q == ASSENTA) ? W'(ASSENTAMENTO - 1) : W'(TIMEOUT - 1);

  contador_timer #(.M(MAX_CONTA)) u_contador (
    .clock  (clock),
    .reset  (reset),
    .clear  (limpa),
    .enable (habilita),
    .limite (limite),
    .fim    (fim)
  );

  always_comb begin
    estado_d  = estado_q;
    posicao_d = posicao_q;
    sentido_d = sentido_q;
    erro_d    = erro_q;
    limpa     = 1'b0;
    habilita  = 1'b0;

    case (estado_q)
      INICIAL: begin
        limpa  = 1'b1;
        erro_d = 1'b0;
        if (ligar) estado_d = POSICIONA;
      end
      POSICIONA: begin
        limpa    = 1'b1;
        estado_d = ASSENTA;
      end
      ASSENTA: begin
        habilita = 1'b1;
        if (fim) estado_d = MEDE;
      end
      MEDE: begin
        limpa    = 1'b1;
        estado_d = AGUARDA;
      end
      AGUARDA: begin
        habilita = 1'b1;
        if (medida_pronta) begin
          estado_d = PROXIMA;
        end else if (fim) begin
          estado_d = PROXIMA;
          erro_d   = 1'b1;
        end
      end
      PROXIMA: begin
        estado_d = POSICIONA;
        // Ping-pong: bounce off the ends instead of wrapping 7 -> 0.
        if (!sentido_q) begin
          if (posicao_q == POS_MAX) begin
            posicao_d = POS_MAX - 3'd1;
            sentido_d = 1'b1;
          end else begin
            posicao_d = posicao_q + 3'd1;
          end
        end else begin
          if (posicao_q == POS_MIN) begin
            posicao_d = POS_MIN + 3'd1;
            sentido_d = 1'b0;
          end else begin
            posicao_d = posicao_q - 3'd1;
          end
        end
      end
      default: estado_d = INICIAL;
    endcase

    if (!ligar && (estado_q != INICIAL)) begin
      estado_d = INICIAL;
      erro_d   = erro_q;
    end

    if (estado_d == INICIAL) begin
      posicao_d = POS_MIN;
      sentido_d = 1'b0;
    end

    medir_d      = (estado_d == MEDE);
    pronto_pos_d = (estado_d == PROXIMA);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q     <= INICIAL;
      posicao_q    <= POS_MIN;
      sentido_q    <= 1'b0;
      medir_q      <= 1'b0;
      pronto_pos_q <= 1'b0;
      erro_q       <= 1'b0;
    end else begin
      estado_q     <= estado_d;
      posicao_q    <= posicao_d;
      sentido_q    <= sentido_d;
      medir_q      <= medir_d;
      pronto_pos_q <= pronto_pos_d;
      erro_q       <= erro_d;
    end
  end

  assign posicao      = posicao_q;
  assign sentido      = sentido_q;
  assign medir        = medir_q;
  assign pronto_pos   = pronto_pos_q;
  assign erro_timeout = erro_q;
  assign db_estado    = estado_q;

endmodule

// File: tb/tb_controle_varredura_servo.sv
// Directed self-checking bench for the servo sweep sequencer (ASSENTAMENTO=4, TIMEOUT=10).
module tb_controle_varredura_servo;

  localparam int ASS = 4;
  localparam int TMO = 10;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ligar = 1'b0;
  logic       medida_pronta = 1'b0;
  logic [2:0] posicao;
  logic       medir;
  logic       pronto_pos;
  logic       erro_timeout;
  logic       sentido;
  logic [3:0] db_estado;

  int checks = 0;
  int fails  = 0;

  controle_varredura_servo #(.ASSENTAMENTO(ASS), .TIMEOUT(TMO)) dut (
    .clock         (clock),
    .reset         (reset),
    .ligar         (ligar),
    .medida_pronta (medida_pronta),
    .posicao       (posicao),
    .medir         (medir),
    .pronto_pos    (pronto_pos),
    .erro_timeout  (erro_timeout),
    .sentido       (sentido),
    .db_estado     (db_estado)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, " estado"},  db_estado, 0);
    checkOutput({tag, " posicao"}, posicao, 0);
    checkOutput({tag, " sentido"}, sentido, 0);
    checkOutput({tag, " medir"},   medir, 0);
    checkOutput({tag, " pronto"},  pronto_pos, 0);
  endtask

  task automatic doReset();
    reset = 1'b1;
    ligar = 1'b0;
    medida_pronta = 1'b0;
    step();
    step();
    reset = 1'b0;
    checkIdle("reset");
    checkOutput("reset erro", erro_timeout, 0);
    ligar = 1'b1;
    step();
  endtask

  // Entered just after the edge that moved the FSM into POSICIONA.
  // resp: AGUARDA cycle in which medida_pronta is pulsed (0 = never).
  // mode: 0 normal, 1 drop ligar on 2nd AGUARDA cycle, 2 reset on 2nd ASSENTA cycle.
  task automatic applyStimulus(input int pos, input int sent, input int resp,
                               input int erro_antes, input int erro_depois,
                               input int mode, input bit pulso_assenta);
    int n;
    checkOutput("posiciona estado", db_estado, 1);
    checkOutput("posiciona posicao", posicao, pos);
    checkOutput("posiciona sentido", sentido, sent);
    checkOutput("posiciona erro", erro_timeout, erro_antes);
    checkOutput("posiciona pronto", pronto_pos, 0);
    for (int i = 0; i < ASS; i++) begin
      if (pulso_assenta && i == 1) medida_pronta = 1'b1;
      step();
      medida_pronta = 1'b0;
      checkOutput("assenta estado", db_estado, 2);
      checkOutput("assenta medir", medir, 0);
      if (mode == 2 && i == 1) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
        checkIdle("reset meio");
        checkOutput("reset meio erro", erro_timeout, 0);
        return;
      end
    end
    step();
    checkOutput("mede estado", db_estado, 3);
    checkOutput("mede medir", medir, 1);
    step();
    n = (resp != 0) ? resp : TMO;
    for (int j = 1; j <= n; j++) begin
      checkOutput("aguarda estado", db_estado, 4);
      checkOutput("aguarda medir", medir, 0);
      if (mode == 1 && j == 2) begin
        ligar = 1'b0;
        step();
        checkIdle("aborta");
        return;
      end
      if (j == resp) medida_pronta = 1'b1;
      step();
      medida_pronta = 1'b0;
    end
    checkOutput("proxima estado", db_estado, 5);
    checkOutput("proxima pronto", pronto_pos, 1);
    checkOutput("proxima posicao", posicao, pos);
    checkOutput("proxima erro", erro_timeout, erro_depois);
    step();
    checkOutput("pos proxima pronto", pronto_pos, 0);
  endtask

  initial begin
    int seq_pos [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
    int seq_sen [16] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 0};

    $display("[TB] sweep with response 3 cycles after medir");
    doReset();
    for (int k = 0; k < 16; k++) applyStimulus(seq_pos[k], seq_sen[k], 3, 0, 0, 0, 1'b0);

    $display("[TB] timeout is sticky and sweep continues");
    doReset();
    applyStimulus(0, 0, 0, 0, 1, 0, 1'b0);
    applyStimulus(1, 0, 3, 1, 1, 0, 1'b0);
    applyStimulus(2, 0, 0, 1, 1, 0, 1'b0);

    $display("[TB] response on the timeout cycle");
    doReset();
    applyStimulus(0, 0, TMO, 0, 0, 0, 1'b0);
    applyStimulus(1, 0, 1, 0, 0, 0, 1'b0);

    $display("[TB] medida_pronta during settle is ignored");
    doReset();
    applyStimulus(0, 0, 3, 0, 0, 0, 1'b1);
    applyStimulus(1, 0, 2, 0, 0, 0, 1'b1);

    $display("[TB] ligar dropped in AGUARDA at posicao 5");
    doReset();
    for (int k = 0; k < 5; k++) applyStimulus(k, 0, 3, 0, 0, 0, 1'b0);
    applyStimulus(5, 0, 3, 0, 0, 1, 1'b0);
    step();
    checkIdle("parado");
    ligar = 1'b1;
    step();
    applyStimulus(0, 0, 3, 0, 0, 0, 1'b0);

    $display("[TB] reset in ASSENTA at posicao 3");
    doReset();
    applyStimulus(0, 0, 0, 0, 1, 0, 1'b0);
    applyStimulus(1, 0, 3, 1, 1, 0, 1'b0);
    applyStimulus(2, 0, 3, 1, 1, 0, 1'b0);
    applyStimulus(3, 0, 3, 1, 1, 2, 1'b0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
